// File: rtl/johnson_dec_chk_pkg.sv
// Shared definitions for the Johnson counter family: lock-tracking FSM states
// and the phase-index width helper.
package johnson_dec_chk_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } jstate_t;

    // An N-stage ring has 2N phases; this returns the bits needed to index them.
    function automatic int idx_w(input int n);
        return $clog2(2 * n);
    endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational Johnson-code decoder: maps an N-bit twisted-ring code to its
// phase index 0..2N-1 and flags any pattern that is not on the ring.
module johnson_decode
    import johnson_dec_chk_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  jcode,
    output logic          legal,
    output logic [IW-1:0] idx_next
);

    // Low k bits set, the rest clear; k = N yields all ones.
    function automatic logic [N-1:0] therm(input int k);
        logic [N-1:0] ones;
        ones = '1;
        return ~(ones << k);
    endfunction

    // First half of the ring fills from the LSB, second half empties from it.
    always_comb begin
        legal    = 1'b0;
        idx_next = '0;
        for (int k = 0; k <= N; k++) begin
            if (jcode == therm(k)) begin
                legal    = 1'b1;
                idx_next = IW'(k);
            end
        end
        for (int m = 1; m < N; m++) begin
            if (jcode == ~therm(m)) begin
                legal    = 1'b1;
                idx_next = IW'(N + m);
            end
        end
    end

endmodule

// File: rtl/johnson_dec_chk.sv
// Johnson code receiver: samples on en, decodes the phase, flags illegal codes
// and out-of-sequence steps, and tracks lock to the ring with a small FSM.
module johnson_dec_chk
    import johnson_dec_chk_pkg::*;
#(
    parameter int N          = 4,
    parameter int LOCK_CNT   = 3,
    parameter int UNLOCK_CNT = 2,
    parameter int ERR_W      = 8,
    localparam int IW = idx_w(N)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             en,
    input  logic [N-1:0]     jcode,
    output logic [IW-1:0]    idx,
    output logic             idx_vld,
    output logic             code_err,
    output logic             seq_err,
    output logic             locked,
    output logic [ERR_W-1:0] err_cnt,
    output jstate_t          state
);

    localparam int RW = $clog2(LOCK_CNT + 1);
    localparam int MW = $clog2(UNLOCK_CNT + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(2 * N - 1);

    logic          dec_legal;
    logic [IW-1:0] dec_idx;
    logic [IW-1:0] exp_idx;
    logic          seq_bad;
    logic          bad;
    logic          have_prev;

    jstate_t       state_nxt;
    logic [RW-1:0] run, run_nxt, run_inc;
    logic [MW-1:0] miss, miss_nxt, miss_inc;

    johnson_decode #(.N(N)) u_decode (
        .jcode    (jcode),
        .legal    (dec_legal),
        .idx_next (dec_idx)
    );

    // The step after the last phase wraps back to phase 0.
    assign exp_idx  = (idx == LAST_IDX) ? '0 : idx + 1'b1;
    assign seq_bad  = dec_legal & have_prev & (dec_idx != exp_idx);
    assign bad      = ~dec_legal | seq_bad;
    assign run_inc  = run + 1'b1;
    assign miss_inc = miss + 1'b1;
    assign locked   = (state == LOCKED);

    always_comb begin
        state_nxt = state;
        run_nxt   = run;
        miss_nxt  = miss;
        if (en) begin
            case (state)
                HUNT: begin
                    if (!bad) begin
                        run_nxt   = RW'(1);
                        state_nxt = (LOCK_CNT <= 1) ? LOCKED : ACQ;
                    end
                end
                ACQ: begin
                    if (bad) begin
                        state_nxt = HUNT;
                        run_nxt   = '0;
                    end else begin
                        run_nxt = run_inc;
                        if (run_inc >= RW'(LOCK_CNT)) begin
                            state_nxt = LOCKED;
                            miss_nxt  = '0;
                        end
                    end
                end
                LOCKED: begin
                    if (!bad) begin
                        miss_nxt = '0;
                    end else if (miss_inc >= MW'(UNLOCK_CNT)) begin
                        state_nxt = HUNT;
                        run_nxt   = '0;
                        miss_nxt  = '0;
                    end else begin
                        miss_nxt = miss_inc;
                    end
                end
                default: begin
                    state_nxt = HUNT;
                    run_nxt   = '0;
                    miss_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= HUNT;
            run   <= '0;
            miss  <= '0;
        end else begin
            state <= state_nxt;
            run   <= run_nxt;
            miss  <= miss_nxt;
        end
    end

    // An illegal code breaks the sequence chain, so the next legal sample
    // starts a fresh comparison instead of raising seq_err.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            idx       <= '0;
            idx_vld   <= 1'b0;
            code_err  <= 1'b0;
            seq_err   <= 1'b0;
            err_cnt   <= '0;
            have_prev <= 1'b0;
        end else if (en) begin
            idx_vld   <= dec_legal;
            code_err  <= ~dec_legal;
            seq_err   <= seq_bad;
            have_prev <= dec_legal;
            if (dec_legal) begin
                idx <= dec_idx;
            end
            if (bad && !(&err_cnt)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end else begin
            idx_vld  <= 1'b0;
            code_err <= 1'b0;
            seq_err  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_johnson_dec_chk.sv
// Bench for johnson_dec_chk: directed ring walks plus random strobes, checked
// cycle by cycle against a phase-table reference model through a scoreboard.
module tb_johnson_dec_chk;
    import johnson_dec_chk_pkg::*;

    localparam int N      = 4;
    localparam int P      = 2 * N;
    localparam int LOCK   = 3;
    localparam int UNLOCK = 2;
    localparam int EW     = 19;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       en = 1'b0;
    logic [3:0] jcode = 4'd0;

    logic [2:0] idx, idx_s;
    logic       idx_vld, code_err, seq_err, locked;
    logic       idx_vld_s, code_err_s, seq_err_s, locked_s;
    logic [7:0] err_cnt;
    logic [1:0] err_cnt_s;
    jstate_t    state, state_s;

    johnson_dec_chk #(.N(N), .LOCK_CNT(LOCK), .UNLOCK_CNT(UNLOCK), .ERR_W(8)) dut (
        .clk(clk), .n_rst(n_rst), .en(en), .jcode(jcode), .idx(idx),
        .idx_vld(idx_vld), .code_err(code_err), .seq_err(seq_err),
        .locked(locked), .err_cnt(err_cnt), .state(state)
    );

    johnson_dec_chk #(.N(N), .LOCK_CNT(LOCK), .UNLOCK_CNT(UNLOCK), .ERR_W(2)) dut_small (
        .clk(clk), .n_rst(n_rst), .en(en), .jcode(jcode), .idx(idx_s),
        .idx_vld(idx_vld_s), .code_err(code_err_s), .seq_err(seq_err_s),
        .locked(locked_s), .err_cnt(err_cnt_s), .state(state_s)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];
    string         name_q[$];

    // Reference model state, expressed in terms of ring phases.
    int      code_of[P];
    int      m_prev;
    bit      m_have;
    jstate_t m_mode;
    int      m_run, m_miss, m_err;

    function automatic logic [EW-1:0] pack(input logic v, input logic c, input logic s,
                                           input logic l, input logic [2:0] i,
                                           input logic [7:0] e, input logic [1:0] e2,
                                           input jstate_t st);
        return {v, c, s, l, i, e, e2, st};
    endfunction

    function automatic logic [EW-1:0] actual();
        return pack(idx_vld, code_err, seq_err, locked, idx, err_cnt, err_cnt_s, state);
    endfunction

    task automatic model_reset();
        m_prev = 0; m_have = 0; m_mode = HUNT; m_run = 0; m_miss = 0; m_err = 0;
    endtask

    // Drive one cycle at the falling edge and queue what the next rising edge must produce.
    task automatic drive(input logic en_v, input logic [3:0] code, input string tag);
        int  p;
        bit  v, c, s, bad;
        @(negedge clk);
        en = en_v;
        jcode = code;
        v = 0; c = 0; s = 0; bad = 0;
        if (en_v) begin
            p = -1;
            for (int k = 0; k < P; k++) if (code_of[k] == int'(code)) p = k;
            if (p < 0) begin
                c = 1; bad = 1; m_have = 0;
            end else begin
                v = 1;
                s = m_have && (p != (m_prev + 1) % P);
                bad = s;
                m_prev = p;
                m_have = 1;
            end
            if (bad) m_err++;
            case (m_mode)
                HUNT: if (!bad) begin m_run = 1; m_mode = (LOCK <= 1) ? LOCKED : ACQ; end
                ACQ: begin
                    if (bad) begin m_mode = HUNT; m_run = 0; end
                    else begin
                        m_run++;
                        if (m_run >= LOCK) begin m_mode = LOCKED; m_miss = 0; end
                    end
                end
                default: begin
                    if (!bad) m_miss = 0;
                    else begin
                        m_miss++;
                        if (m_miss >= UNLOCK) begin m_mode = HUNT; m_run = 0; m_miss = 0; end
                    end
                end
            endcase
        end
        exp_q.push_back(pack(v, c, s, m_mode == LOCKED, 3'(m_prev),
                             8'((m_err > 255) ? 255 : m_err),
                             2'((m_err > 3) ? 3 : m_err), m_mode));
        name_q.push_back(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        n_rst = 1'b0;
        en = 1'b0;
        #2;
        checks++;
        if (actual() !== pack(0, 0, 0, 0, 3'd0, 8'd0, 2'd0, HUNT)) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, actual(), pack(0, 0, 0, 0, 3'd0, 8'd0, 2'd0, HUNT));
        end
        model_reset();
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    // Monitor: one expected entry is consumed after each rising edge it was queued for.
    initial begin
        logic [EW-1:0] e;
        string         t;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = name_q.pop_front();
                checks++;
                if (actual() !== e) begin
                    errors++;
                    $display("FAIL %s: got vld/cerr/serr/lck/idx/err/err2/st=%b/%b/%b/%b/%0d/%0d/%0d/%0d want %b/%b/%b/%b/%0d/%0d/%0d/%0d",
                             t, idx_vld, code_err, seq_err, locked, idx, err_cnt, err_cnt_s, state,
                             e[18], e[17], e[16], e[15], e[14:12], e[11:4], e[3:2], e[1:0]);
                end
            end
        end
    end

    initial begin
        logic [3:0] illegal_tab[5];
        int         r, nxt;
        for (int p = 0; p < P; p++)
            code_of[p] = (p <= N) ? ((1 << p) - 1) : (((1 << N) - 1) & ~((1 << (p - N)) - 1));
        illegal_tab[0] = 4'b1010; illegal_tab[1] = 4'b0101; illegal_tab[2] = 4'b1001;
        illegal_tab[3] = 4'b0110; illegal_tab[4] = 4'b1011;
        model_reset();

        do_reset("reset_init");
        for (int p = 0; p < P; p++) drive(1'b1, 4'(code_of[p]), "ring_walk");
        for (int p = 0; p < 4; p++) drive(1'b1, 4'(code_of[p]), "relock_to_3");
        drive(1'b1, 4'b0101, "illegal_while_locked");
        drive(1'b1, 4'b0101, "second_bad_unlocks");
        for (int p = 0; p < 3; p++) drive(1'b1, 4'(code_of[p]), "lock_to_2");
        drive(1'b1, 4'b1110, "seq_jump_to_5");
        drive(1'b1, 4'b1100, "recover_6");
        drive(1'b1, 4'b1000, "step_7");
        drive(1'b1, 4'b0000, "wrap_to_0");
        drive(1'b1, 4'b0000, "repeat_code");
        for (int i = 0; i < 5; i++) drive(1'b0, 4'($urandom_range(0, 15)), "en_low_hold");
        for (int i = 0; i < 5; i++) drive(1'b1, illegal_tab[i], "err_saturate");
        drive(1'b1, 4'(code_of[1]), "acq_1");
        drive(1'b1, 4'(code_of[2]), "acq_2");
        do_reset("reset_mid_acq");

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            nxt = m_have ? (m_prev + 1) % P : $urandom_range(0, P - 1);
            if (r < 55)      drive($urandom_range(0, 3) != 0, 4'(code_of[nxt]), "rand_next");
            else if (r < 80) drive($urandom_range(0, 3) != 0, 4'(code_of[$urandom_range(0, P - 1)]), "rand_legal");
            else             drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), "rand_any");
        end

        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/johnson_dec_chk.md
Name: johnson_dec_chk

Overview:
- Receiving end of the team's N-stage Johnson (twisted-ring) counter output.
- Samples a Johnson-coded vector on a strobe and decodes it to a binary phase index.
- Flags illegal codes and out-of-sequence steps.
- Tracks lock to the expected ring sequence with a small FSM and a saturating error counter; used for counter self-check and phase recovery.

Parameters:
- N, 4, number of Johnson stages (≥2); ring period = 2N.
- LOCK_CNT, 3, consecutive good steps needed to declare lock (≥1).
- UNLOCK_CNT, 2, consecutive bad samples while locked that drop lock (≥1).
- ERR_W, 8, width of saturating error counter.

Ports:
- clk  in  1  clock.
- n_rst  in  1  asynchronous, active-low reset.
- en  in  1  sample strobe; jcode is evaluated only when en=1.
- jcode  in  N  Johnson code; bit0 = stage fed by inverted bit N-1.
- idx  out  IW=$clog2(2N)  decoded phase 0..2N-1 (registered).
- idx_vld  out  1  one-cycle pulse: idx updated from a legal code.
- code_err  out  1  one-cycle pulse: sampled code illegal.
- seq_err  out  1  one-cycle pulse: legal code, but not previous idx+1 mod 2N.
- locked  out  1  high in LOCKED state.
- err_cnt  out  ERR_W  saturating count of code_err + seq_err events.

Behaviour:
- Reset (async, n_rst=0): idx=0, idx_vld=0, code_err=0, seq_err=0, locked=0, err_cnt=0, FSM=HUNT, have_prev=0.
- Legal codes:
  - Thermometer of k ones from LSB (k=0..N) → idx=k.
  - All ones with the low m bits zero (m=1..N-1) → idx=N+m.
  - Any other pattern → illegal. Example, N=4: 0000→0, 0001→1, 0011→2, 0111→3, 1111→4, 1110→5, 1100→6, 1000→7.
- Latency: outputs register on the clk edge where en=1; visible in the next cycle. With en=0, pulses deassert and idx, locked and err_cnt hold.
- Illegal code: code_err=1, idx_vld=0, idx holds, have_prev cleared (next legal sample cannot raise seq_err), counts as bad.
- Legal code:
  - idx_vld=1, idx=decoded value.
  - If have_prev=1 and decoded ≠ (idx+1) mod 2N → seq_err=1, counts as bad; otherwise good.
  - The first legal sample after reset or an illegal code is good.
  - A repeated code counts as seq_err.
  - Wrap 2N-1→0 is good.
  - have_prev set.
- err_cnt: +1 on any bad sample; saturates at 2^ERR_W-1. code_err and seq_err are never both set.
- FSM (advances only on en=1):
  - HUNT: a good legal sample → ACQ, run=1, or LOCKED directly if LOCK_CNT=1. Bad → stay.
  - ACQ: good → run+1; run reaching LOCK_CNT → LOCKED. Bad → HUNT, run=0.
  - LOCKED: good → miss=0. Bad → miss+1; miss reaching UNLOCK_CNT → HUNT, run=0, miss=0.
  - locked=1 only in LOCKED.
- Reset mid-operation: immediate return to reset values regardless of state; no pulse is emitted.

Decomposition:
- Shared package: FSM state enum (HUNT, ACQ, LOCKED) and a function computing IW from N. The package is reused by the Johnson counter family.
- One natural sub-module: johnson_decode (purely combinational: jcode → legal, idx_next), so the counter testbench can reuse it as a reference model.
- Top holds the registers, the sequence compare, the FSM and the error counter.

Test Plan:
- Reset, then 8 strobes of 0000,0001,0011,0111,1111,1110,1100,1000 (N=4):
  - idx=0..7, idx_vld on every strobe, no errors.
  - locked=1 after the 3rd sample.
  - err_cnt=0.
- Locked, inject 0101:
  - code_err=1, idx holds 3 (previous value), err_cnt=1, locked stays 1.
  - A second bad sample drops locked to 0.
- Locked at idx=2, apply 1110 (idx 5):
  - seq_err=1, idx=5, err_cnt+1.
  - Then 1100 is good (6 = 5+1) and resets the miss count.
- Wrap: 1000 then 0000 → idx 7→0 with no seq_err; same code applied twice → seq_err on the second.
- en held low for 5 cycles with a changing jcode → all pulses 0, idx, locked and err_cnt unchanged.
- ERR_W=2, 5 illegal samples → err_cnt saturates at 3. Assert n_rst mid-ACQ → all outputs 0, state HUNT.
